// File: rtl/ifetch_queue.sv
// Instruction fetch unit: issues one word read at a time and buffers the
// returned {pc, inst} pairs in a small circular queue that feeds the decoder.
module ifetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        dec_redirect,
    input  logic [31:0] dec_redirect_pc,
    input  logic        dec_ready,
    output logic        if2dec,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_inst
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // state  | meaning
    // S_IDLE | no request outstanding
    // S_WAIT | request outstanding, response will be queued
    // S_DROP | request outstanding, response is stale and will be discarded
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      qpc_q   [QUEUE_DEPTH];
    logic [31:0]      qinst_q [QUEUE_DEPTH];

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        issue;
    logic        push;
    logic        pop;

    // Redirects and pops are frozen while the block is paused; responses are not.
    assign redirect    = rdy_in & (flush | dec_redirect);
    assign redirect_pc = flush ? flush_pc : dec_redirect_pc;
    assign issue       = (state_q == S_IDLE) & rdy_in & ~flush & ~dec_redirect
                         & (count_q < CNT_W'(QUEUE_DEPTH));
    assign push        = (state_q == S_WAIT) & mem_valid & ~redirect;
    assign pop         = if2dec;

    assign if2dec   = (count_q != '0) & dec_ready & rdy_in & ~flush & ~dec_redirect;
    assign pc_out   = qpc_q[head_q];
    assign inst_out = qinst_q[head_q];

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (issue) state_d = S_WAIT;
            S_WAIT: begin
                if (mem_valid)     state_d = S_IDLE;
                else if (redirect) state_d = S_DROP;
            end
            S_DROP: if (mem_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q == S_WAIT) | (state_q == S_DROP);
        mem_addr = req_pc_q;
    end

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (issue) req_pc_d = pc_q;
        if (push)  pc_d     = req_pc_q + 32'd4;
        if (redirect) begin
            pc_d    = redirect_pc;
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                qpc_q[i]   <= '0;
                qinst_q[i] <= '0;
            end
        end else if (push) begin
            qpc_q[tail_q]   <= req_pc_q;
            qinst_q[tail_q] <= mem_inst;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model with a simple latency memory.
module tb_ifetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        dec_redirect = 1'b0;
    logic [31:0] dec_redirect_pc = '0;
    logic        dec_ready = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_inst = '0;
    logic        if2dec;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        mem_req;
    logic [31:0] mem_addr;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic        m_busy;
    logic        m_stale;
    int          m_lat;
    int          lat_min;
    int          lat_max;

    ifetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .dec_redirect    (dec_redirect),
        .dec_redirect_pc (dec_redirect_pc),
        .dec_ready       (dec_ready),
        .if2dec          (if2dec),
        .pc_out          (pc_out),
        .inst_out        (inst_out),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_valid       (mem_valid),
        .mem_inst        (mem_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs presented this cycle.
    task automatic model_clock();
        logic        take;
        logic        pop;
        logic        issue;
        logic [31:0] tgt;
        logic [31:0] old_pc;
        entry_t      e;
        take   = rdy_in && (flush || dec_redirect);
        tgt    = flush ? flush_pc : dec_redirect_pc;
        pop    = (mq.size() != 0) && dec_ready && rdy_in && !flush && !dec_redirect;
        issue  = !m_busy && rdy_in && !flush && !dec_redirect && (mq.size() < DEPTH);
        old_pc = m_pc;
        if (pop) void'(mq.pop_front());
        if (m_busy && mem_valid) begin
            if (!m_stale && !take) begin
                e.pc   = m_req_pc;
                e.inst = mem_inst;
                mq.push_back(e);
                m_pc = m_req_pc + 32'd4;
            end
            m_busy  = 1'b0;
            m_stale = 1'b0;
        end else if (m_busy) begin
            if (take) m_stale = 1'b1;
            if (m_lat > 0) m_lat--;
        end
        if (take) begin
            mq.delete();
            m_pc = tgt;
        end
        if (issue) begin
            m_busy   = 1'b1;
            m_stale  = 1'b0;
            m_req_pc = old_pc;
            m_lat    = int'($urandom_range(lat_max, lat_min));
        end
    endtask

    // Called with clk low: present memory response, check outputs, clock once.
    task automatic step();
        logic exp_if;
        mem_valid = m_busy && (m_lat == 0);
        mem_inst  = mem_valid ? mem_word(m_req_pc) : $urandom();
        #1;
        exp_if = (mq.size() != 0) && dec_ready && rdy_in && !flush && !dec_redirect;
        check("mem_req", 32'(mem_req), 32'(m_busy));
        check("mem_addr", mem_addr, m_req_pc);
        check("if2dec", 32'(if2dec), 32'(exp_if));
        if (mq.size() != 0) begin
            check("pc_out", pc_out, mq[0].pc);
            check("inst_out", inst_out, mq[0].inst);
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_in    = 1'b0;
        mem_valid = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if2dec", 32'(if2dec), 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_inst_out", inst_out, 32'h0);
        mq.delete();
        m_pc     = RPC;
        m_req_pc = '0;
        m_busy   = 1'b0;
        m_stale  = 1'b0;
        m_lat    = 0;
        @(posedge clk);
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    initial begin
        lat_min = 2;
        lat_max = 2;
        #2;
        do_reset();

        // first fetch after reset, 3-cycle memory
        rdy_in = 1'b1; dec_ready = 1'b1;
        step();
        check("r033_req", 32'(mem_req), 32'h1);
        check("r033_addr", mem_addr, 32'h0);
        for (int i = 0; i < 10 && !if2dec; i++) step();
        check("r033_if2dec", 32'(if2dec), 32'h1);
        check("r033_pc", pc_out, 32'h0);
        check("r033_inst", inst_out, 32'h00000013);
        step();
        check("r033_next_addr", mem_addr, 32'h4);

        // fill the queue with decoder stalled, then drain in order
        do_reset();
        lat_min = 0; lat_max = 3;
        rdy_in = 1'b1; dec_ready = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("r034_mem_req", 32'(mem_req), 32'h0);
        check("r034_head", pc_out, 32'h0);
        dec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("r034_pop_order", pc_out, 32'(4 * k));
            step();
        end

        // flush while waiting on address 8
        do_reset();
        lat_min = 3; lat_max = 3;
        rdy_in = 1'b1; dec_ready = 1'b0;
        for (int i = 0; i < 60 && !(mem_req && mem_addr == 32'h8); i++) step();
        check("r035_wait8", 32'(mem_req && mem_addr == 32'h8), 32'h1);
        flush = 1'b1; flush_pc = 32'h100;
        step();
        flush = 1'b0; dec_ready = 1'b1;
        check("r035_empty", 32'(if2dec), 32'h0);
        check("r035_drop_req", 32'(mem_req), 32'h1);
        for (int i = 0; i < 20 && !(mem_req && mem_addr == 32'h100); i++) step();
        check("r035_new_addr", mem_addr, 32'h100);

        // flush + redirect in the same cycle as the response
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20 && !(mem_req && m_lat == 0); i++) step();
        check("r036_wait", 32'(mem_req), 32'h1);
        flush = 1'b1; flush_pc = 32'h300;
        dec_redirect = 1'b1; dec_redirect_pc = 32'h200;
        step();
        flush = 1'b0; dec_redirect = 1'b0;
        check("r036_no_push", 32'(if2dec), 32'h0);
        check("r036_idle", 32'(mem_req), 32'h0);
        step();
        check("r036_addr", mem_addr, 32'h300);

        // pause for 5 cycles with a response landing; a flush is ignored
        for (int i = 0; i < 20 && !(mem_req && m_lat == 2); i++) step();
        check("r037_wait", 32'(mem_req), 32'h1);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flush    = (i == 4);
            flush_pc = 32'h400;
            step();
        end
        flush = 1'b0;
        check("r037_no_req", 32'(mem_req), 32'h0);
        check("r037_no_pop", 32'(if2dec), 32'h0);
        rdy_in = 1'b1;
        #1;
        check("r037_resume_if2dec", 32'(if2dec), 32'h1);
        step();
        check("r037_resume_req", 32'(mem_req), 32'h1);

        // reset in the middle of an outstanding request
        for (int i = 0; i < 20 && !mem_req; i++) step();
        check("r038_wait", 32'(mem_req), 32'h1);
        do_reset();
        step();
        check("r038_req", 32'(mem_req), 32'h1);
        check("r038_addr", mem_addr, RPC);

        // random traffic
        lat_min = 0; lat_max = 4;
        for (int n = 0; n < 3000; n++) begin
            rdy_in          = ($urandom_range(9, 0) != 0);
            dec_ready       = ($urandom_range(2, 0) != 0);
            flush           = ($urandom_range(24, 0) == 0);
            dec_redirect    = ($urandom_range(19, 0) == 0);
            flush_pc        = $urandom() & 32'hFFFF_FFFC;
            dec_redirect_pc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(499, 0) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, instruction-queue entries; power of two, 2 to 16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, fetch PC after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rdy_in  input  1  global ready; low pauses the block.
REQ-006 SHALL have port flush  input  1  mispredict flush from reorder buffer.
REQ-007 SHALL have port flush_pc  input  32  restart PC for flush.
REQ-008 SHALL have port dec_redirect  input  1  decoder redirect (jal/predicted branch).
REQ-009 SHALL have port dec_redirect_pc  input  32  decoder target PC.
REQ-010 SHALL have port dec_ready  input  1  decoder can accept an instruction this cycle.
REQ-011 SHALL have port if2dec  output  1  head entry valid and handed to decoder.
REQ-012 SHALL have port pc_out  output  32  PC of head entry.
REQ-013 SHALL have port inst_out  output  32  instruction word of head entry.
REQ-014 SHALL have port mem_req  output  1  instruction read request, level until served.
REQ-015 SHALL have port mem_addr  output  32  word address of outstanding request.
REQ-016 SHALL have port mem_valid  input  1  one-cycle pulse, response for mem_addr.
REQ-017 SHALL have port mem_inst  input  32  returned instruction word, valid with mem_valid.

Function
REQ-018 SHALL hold fetch PC, request PC (req_pc), a QUEUE_DEPTH circular queue of {pc,inst}, head/tail pointers, count (log2(DEPTH)+1 bits) and FSM state IDLE/WAIT/DROP.
REQ-019 SHALL drive mem_req=1 exactly when state is WAIT or DROP; mem_addr=req_pc always.
REQ-020 SHALL in IDLE, with rdy_in=1, no flush, no dec_redirect, and count<DEPTH, latch req_pc<=pc and enter WAIT.
REQ-021 SHALL in WAIT on mem_valid push {req_pc, mem_inst} at tail, set pc<=req_pc+4 (mod 2^32), return to IDLE; next request no earlier than following cycle.
REQ-022 SHALL never push when full; issue gating (REQ-020) guarantees a free slot per outstanding request.
REQ-023 SHALL drive if2dec = (count!=0) & dec_ready & rdy_in & ~flush & ~dec_redirect, combinationally; pc_out/inst_out = head entry regardless of if2dec.
REQ-024 SHALL pop head on cycles where if2dec=1; simultaneous push and pop leaves count unchanged and both pointers advance, wrapping modulo DEPTH.
REQ-025 SHALL on flush: clear queue (count=0, head=tail), pc<=flush_pc; WAIT->DROP, IDLE stays IDLE, DROP stays DROP.
REQ-026 SHALL on dec_redirect without flush: behave as REQ-025 using dec_redirect_pc; flush has priority when both high.
REQ-027 SHALL in DROP keep mem_req high, discard the response on mem_valid (no push, pc unchanged), then go IDLE.
REQ-028 SHALL, with mem_valid and flush/dec_redirect in the same WAIT cycle, discard the response and go IDLE with pc set to the new target.
REQ-029 SHALL with rdy_in=0 issue no request, pop nothing, ignore flush/dec_redirect, but still capture mem_valid per REQ-021/REQ-027.
REQ-030 SHALL give one-cycle latency from a captured response to if2dec=1 (empty queue, dec_ready=1).

Reset
REQ-031 SHALL on rst_in=0, immediately and independent of clk: pc=RESET_PC, req_pc=0, queue empty, pointers 0, state IDLE; hence if2dec=0, mem_req=0, mem_addr=0, pc_out/inst_out=0.
REQ-032 SHALL discard any in-flight request on reset, without entering DROP.

Verification
REQ-033 SHALL verify: release reset, memory answers after 3 cycles with 32'h00000013 -> mem_addr=0, then if2dec=1 with pc_out=0, next mem_addr=4.
REQ-034 SHALL verify: dec_ready=0, DEPTH=4 -> four entries PC 0,4,8,12 queued, mem_req stays 0; dec_ready=1 pops in order.
REQ-035 SHALL verify: flush with flush_pc=32'h100 while WAIT at 8 -> queue empty, stale response dropped, next mem_addr=32'h100.
REQ-036 SHALL verify: flush and dec_redirect (32'h200) same cycle as mem_valid -> no push, next mem_addr = flush_pc.
REQ-037 SHALL verify: rdy_in=0 for 5 cycles with one response arriving -> entry captured, no pop, no new request; resumes when rdy_in=1.
REQ-038 SHALL verify: rst_in asserted mid-WAIT -> mem_req=0 asynchronously; after release first mem_addr=RESET_PC.
